spis_stream: RTL and testbench
==============================

# spis_stream

Parametrised SPI slave. It bridges an external SPI master onto two AXI-Stream channels. Generalises the byte-wide SPI slave:
- configurable word width and bit order
- input synchronisers for the asynchronous SPI pins
- independent TX and RX FIFOs
- underrun/overrun reporting

It sits at the chip edge between the SPI pins and the register/command fabric.

## Interface
Parameters:
- DW, 8, word width in bits, 4..32
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO
- TX_DEPTH, 4, MISO FIFO depth, power of 2, ≥2
- RX_DEPTH, 4, MOSI FIFO depth, power of 2, ≥2
- SYNC_STAGES, 2, flops per input synchroniser, ≥2

Ports:
- clk  in  1  system clock; everything is sampled on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DW  word to transmit on MISO
- s_axis_tvalid  in  1  TX word valid
- s_axis_tready  out  1  equals !tx_full
- m_axis_tdata  out  DW  word received on MOSI
- m_axis_tvalid  out  1  equals !rx_empty
- m_axis_tready  in  1  RX consumer ready
- cs  in  1  chip select, active-low, asynchronous to clk
- sclk  in  1  SPI clock, asynchronous to clk
- mosi  in  1  serial data in, asynchronous to clk
- miso  out  1  serial data out; 0 while cs is high (no tristate)
- tx_underrun  out  1  one-cycle pulse: word start with TX FIFO empty
- rx_overrun  out  1  one-cycle pulse: RX word dropped because RX FIFO full

## Operation
- **Input path.** cs, sclk and mosi each pass through SYNC_STAGES flops. One extra register on synced cs and sclk gives the edge flags cs_fall, cs_rise, sclk_rise and sclk_fall.
- **Edge roles.** sample_edge = sclk_rise when CPOL==CPHA, else sclk_fall. update_edge = the opposite edge.
- **TX bit event.** Defined as (CPHA==0 && cs_fall) || (!cs && update_edge). tx_cnt runs 0..DW-1 and wraps to 0.
  - Event with tx_cnt==0: pop the TX FIFO into the shift register and drive its first bit.
  - If the TX FIFO is empty at that event: load all zeros and pulse tx_underrun.
  - Event with tx_cnt!=0: shift and drive the next bit.
- **RX.** On each !cs && sample_edge, shift the synced mosi into rx_shift and increment rx_cnt.
  - On the DW-th bit, push the assembled word into the RX FIFO and clear rx_cnt.
  - If the RX FIFO is full, drop the word and pulse rx_overrun. The FIFO contents are untouched.
- **cs rise (mid-word or not).**
  - Clear tx_cnt, rx_cnt and both shift registers; the partial RX word is discarded.
  - A popped but partly sent TX word is lost and is not re-queued.
  - miso goes to 0.
- **Simultaneous events.**
  - RX FIFO push and m_axis pop in the same cycle on a full FIFO: the push succeeds, with no overrun.
  - TX pop and s_axis push in the same cycle on an empty FIFO: the pop sees empty, giving underrun. The pushed word is kept for the next word.
- **CPHA=0 end of frame.** The trailing update edge after a word's last bit pops the next TX word. If cs then rises, that word is discarded.
- **Reset.** Both FIFOs empty; all counters and shift registers 0.
  - Outputs during and after reset: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, miso=0, tx_underrun=0, rx_overrun=0.

## Timing
- An edge is detected SYNC_STAGES+1 clk cycles after the pin transition.
- Each SCLK phase must last at least SYNC_STAGES+2 clk cycles. For SYNC_STAGES=2 this gives fSCLK ≤ fclk/8.
- CPHA=0: from cs falling to the first SCLK edge, allow at least SYNC_STAGES+3 clk cycles for the first MISO bit to settle.
- miso changes on the clk edge after update_edge is detected. Pin-to-miso delay is SYNC_STAGES+2 clk cycles.
- RX: rx FIFO written at the clk edge after the final sample_edge is detected. m_axis_tvalid is high from the following cycle.
- FIFOs are first-word-fall-through. AXI handshakes complete on tvalid && tready. No combinational path from the ready inputs to any output.

## Structure
- Package spis_pkg holds:
  - the edge-select function edge_roles(CPOL, CPHA)
  - the localparam helpers CNT_W = $clog2(DW) and PTR_W(depth)
- Sub-module spis_fifo: synchronous FWFT FIFO, parameters DW and DEPTH, async active-low reset. It is instantiated for TX and for RX.
- Synchronisers, edge detection and both shift/count paths live in spis_stream.

## Test plan
- **All four modes.** Mode 0, DW=8: push 0xA5 to TX, master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; m_axis delivers 0x3C. Repeat for modes 1, 2 and 3 with the same data.
- **Width and bit order.** DW=16, MSB_FIRST=0, master sends 0x1234 → m_axis 0x1234 with LSB first on the wire; TX 0xBEEF shifted out LSB first.
- **TX underrun.** TX FIFO empty at cs fall in mode 0 → one tx_underrun pulse; MISO reads 0x00; the next word is from the FIFO if it was filled meanwhile.
- **RX overrun.** RX_DEPTH=4 with m_axis_tready=0, master sends 5 words → 4 held (words 1–4) and one rx_overrun pulse; drained in order.
- **Abort mid-word.** cs rises after 5 bits → no m_axis word, counters cleared; the next full frame is received correctly.
- **Reset mid-frame.** Assert rst_n low mid-frame → all outputs at their reset values immediately; the FIFOs are empty after release.

Source files
------------

// File: rtl/spis_pkg.sv
// spis_pkg: edge-role selection and width helpers shared by the SPI slave and its FIFOs.
package spis_pkg;
  typedef struct packed {
    logic sample_rise;
    logic update_rise;
  } edge_sel_t;
  function automatic edge_sel_t edge_roles(input int cpol, input int cpha);
    edge_sel_t e;
    e.sample_rise = cpol == cpha;
    e.update_rise = cpol != cpha;
    return e;
  endfunction
  function automatic int cnt_w(input int dw);
    return $clog2(dw);
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/spis_fifo.sv
// spis_fifo: first-word-fall-through FIFO; data output reads zero while empty.
module spis_fifo import spis_pkg::*; #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o
);
  localparam int PW = ptr_w(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0] wp_q, wp_d, rp_q, rp_d;
  logic wr_ok, rd_ok;
  // a write into a full FIFO is accepted when a read frees a slot in the same cycle
  always_comb begin
    empty_o   = wp_q == rp_q;
    full_o    = wp_q == {~rp_q[PW], rp_q[PW-1:0]};
    rd_ok     = rd_en_i && !empty_o;
    wr_ok     = wr_en_i && (!full_o || rd_ok);
    wp_d      = wp_q + {{PW{1'b0}}, wr_ok};
    rp_d      = rp_q + {{PW{1'b0}}, rd_ok};
    rd_data_o = empty_o ? '0 : mem_q[rp_q[PW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (wr_ok) mem_q[wp_q[PW-1:0]] <= wr_data_i;
endmodule

// File: rtl/spis_stream.sv
// spis_stream: SPI slave bridging an external master onto AXI-Stream TX (MISO) and RX (MOSI) channels.
module spis_stream import spis_pkg::*; #(
  parameter int DW          = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  input  logic          cs,
  input  logic          sclk,
  input  logic          mosi,
  output logic          miso,
  output logic          tx_underrun,
  output logic          rx_overrun
);
  localparam int CW = cnt_w(DW);
  localparam edge_sel_t ES = edge_roles(CPOL, CPHA);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic cs_prev_q, sclk_prev_q;
  logic cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall, sample_edge, update_edge;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, tx_next, rx_next, tx_word;
  logic miso_q, miso_d, und_q, und_d, ovr_q, ovr_d;
  logic tx_ev, rx_ev, tx_pop, rx_push, tx_full, tx_empty, rx_full, rx_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= {SYNC_STAGES{CPOL != 0}};
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= CPOL != 0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  always_comb begin
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_fall     = cs_prev_q && !cs_s;
    cs_rise     = !cs_prev_q && cs_s;
    sclk_rise   = !sclk_prev_q && sclk_s;
    sclk_fall   = sclk_prev_q && !sclk_s;
    sample_edge = ES.sample_rise ? sclk_rise : sclk_fall;
    update_edge = ES.update_rise ? sclk_rise : sclk_fall;
    tx_ev       = (CPHA == 0 && cs_fall) || (!cs_s && update_edge);
    rx_ev       = !cs_s && sample_edge;
    tx_pop      = tx_ev && tx_cnt_q == '0;
    rx_push     = rx_ev && rx_cnt_q == LAST;
    tx_next     = tx_pop ? tx_word : MSB_FIRST != 0 ? tx_shift_q << 1 : tx_shift_q >> 1;
    rx_next     = MSB_FIRST != 0 ? {rx_shift_q[DW-2:0], mosi_s} : {mosi_s, rx_shift_q[DW-1:1]};
    tx_cnt_d    = cs_rise ? '0 : tx_ev ? (tx_cnt_q == LAST ? '0 : tx_cnt_q + CW'(1)) : tx_cnt_q;
    rx_cnt_d    = cs_rise || rx_push ? '0 : rx_ev ? rx_cnt_q + CW'(1) : rx_cnt_q;
    tx_shift_d  = cs_rise ? '0 : tx_ev ? tx_next : tx_shift_q;
    rx_shift_d  = cs_rise ? '0 : rx_ev ? rx_next : rx_shift_q;
    miso_d      = cs_rise ? 1'b0 : tx_ev ? (MSB_FIRST != 0 ? tx_next[DW-1] : tx_next[0]) : miso_q;
    und_d       = tx_pop && tx_empty;
    ovr_d       = rx_push && rx_full && !m_axis_tready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b0;
      und_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      und_q      <= und_d;
      ovr_q      <= ovr_d;
    end
  spis_fifo #(.DW(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(s_axis_tvalid), .wr_data_i(s_axis_tdata), .full_o(tx_full),
    .rd_en_i(tx_pop), .rd_data_o(tx_word), .empty_o(tx_empty)
  );
  spis_fifo #(.DW(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(rx_push), .wr_data_i(rx_next), .full_o(rx_full),
    .rd_en_i(m_axis_tready), .rd_data_o(m_axis_tdata), .empty_o(rx_empty)
  );
  // the raw pin gates miso so it reads 0 as soon as the master deselects
  assign miso          = miso_q && !cs;
  assign s_axis_tready = !tx_full;
  assign m_axis_tvalid = !rx_empty;
  assign tx_underrun   = und_q;
  assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_spis_stream.sv
// tb_spis_stream: drives four 8-bit SPI-mode builds and a 16-bit LSB-first build against a queue-based model.
module tb_spis_stream;
  localparam int N = 5;
  localparam int H = 6;
  typedef struct {
    int k;
    logic [15:0] tx;
    logic [15:0] mo;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] cs_v, sclk_v, mosi_v, miso_v, s_valid_v, s_ready_v, m_valid_v, m_ready_v, und_v, ovr_v;
  logic [15:0] s_data_a [N];
  logic [15:0] m_data_a [N];
  logic [15:0] tx_q [N][$];
  logic [15:0] rx_q [N][$];
  int und_cnt [N];
  int ovr_cnt [N];
  int und_exp [N];
  int ovr_exp [N];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_mode
    logic [7:0] md;
    spis_stream #(.CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_data_a[g][7:0]), .s_axis_tvalid(s_valid_v[g]), .s_axis_tready(s_ready_v[g]),
      .m_axis_tdata(md), .m_axis_tvalid(m_valid_v[g]), .m_axis_tready(m_ready_v[g]),
      .cs(cs_v[g]), .sclk(sclk_v[g]), .mosi(mosi_v[g]), .miso(miso_v[g]),
      .tx_underrun(und_v[g]), .rx_overrun(ovr_v[g])
    );
    assign m_data_a[g] = {8'h00, md};
  end
  spis_stream #(.DW(16), .MSB_FIRST(0)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data_a[4]), .s_axis_tvalid(s_valid_v[4]), .s_axis_tready(s_ready_v[4]),
    .m_axis_tdata(m_data_a[4]), .m_axis_tvalid(m_valid_v[4]), .m_axis_tready(m_ready_v[4]),
    .cs(cs_v[4]), .sclk(sclk_v[4]), .mosi(mosi_v[4]), .miso(miso_v[4]),
    .tx_underrun(und_v[4]), .rx_overrun(ovr_v[4])
  );
  always @(negedge clk)
    for (int k = 0; k < N; k++) begin
      und_cnt[k] <= und_cnt[k] + int'(und_v[k]);
      ovr_cnt[k] <= ovr_cnt[k] + int'(ovr_v[k]);
    end
  function automatic int dw_of(input int k);
    return k == 4 ? 16 : 8;
  endfunction
  function automatic bit msb_of(input int k);
    return k != 4;
  endfunction
  function automatic logic cpol_of(input int k);
    return k == 4 ? 1'b0 : 1'(k / 2);
  endfunction
  function automatic int cpha_of(input int k);
    return k == 4 ? 0 : k % 2;
  endfunction
  function automatic logic [15:0] mask(input int k);
    return k == 4 ? 16'hFFFF : 16'h00FF;
  endfunction
  function automatic logic [63:0] to_wire(input int k, input logic [15:0] w);
    logic [63:0] s = '0;
    for (int i = 0; i < dw_of(k); i++) s[i] = msb_of(k) ? w[dw_of(k)-1-i] : w[i];
    return s;
  endfunction
  function automatic logic [15:0] from_wire(input int k, input logic [63:0] s, input int idx);
    logic [15:0] w = '0;
    for (int i = 0; i < dw_of(k); i++) w[msb_of(k) ? dw_of(k)-1-i : i] = s[idx*dw_of(k)+i];
    return w;
  endfunction
  function automatic logic [15:0] start_word(input int k);
    if (tx_q[k].size() > 0) return tx_q[k].pop_front();
    und_exp[k]++;
    return 16'h0000;
  endfunction
  function automatic void rx_model(input int k, input logic [15:0] w);
    if (rx_q[k].size() < 4) rx_q[k].push_back(w);
    else ovr_exp[k]++;
  endfunction
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic push(input int k, input logic [15:0] w);
    int t = 0;
    while (!s_ready_v[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready_v[k]) check($sformatf("push_ready_timeout%0d", k), 64'(s_ready_v[k]), 64'd1);
    s_data_a[k] = w & mask(k);
    s_valid_v[k] = 1'b1;
    tx_q[k].push_back(w & mask(k));
    @(negedge clk);
    s_valid_v[k] = 1'b0;
  endtask
  task automatic frame(input int k, input int nbits, input logic [63:0] mo, output logic [63:0] got);
    int dw = dw_of(k);
    logic pol = cpol_of(k);
    logic [63:0] req = '0;
    logic [15:0] w = '0;
    got = '0;
    cs_v[k] = 1'b0;
    if (cpha_of(k) == 0) mosi_v[k] = mo[0];
    wait_cyc(H);
    for (int i = 0; i < nbits; i++) begin
      if (i % dw == 0) w = start_word(k);
      req[i] = msb_of(k) ? w[dw-1-(i%dw)] : w[i%dw];
      if (cpha_of(k) == 0) begin
        got[i] = miso_v[k];
        sclk_v[k] = !pol;
        wait_cyc(H);
        sclk_v[k] = pol;
        if (i + 1 < nbits) mosi_v[k] = mo[i+1];
        wait_cyc(H);
      end else begin
        sclk_v[k] = !pol;
        mosi_v[k] = mo[i];
        wait_cyc(H);
        got[i] = miso_v[k];
        sclk_v[k] = pol;
        wait_cyc(H);
      end
      if (i % dw == dw - 1) rx_model(k, from_wire(k, mo, i / dw));
    end
    if (cpha_of(k) == 0 && nbits % dw == 0) void'(start_word(k));
    cs_v[k] = 1'b1;
    wait_cyc(H);
    check($sformatf("miso_stream%0d", k), got, req);
    check($sformatf("underruns%0d", k), 64'(und_cnt[k]), 64'(und_exp[k]));
    check($sformatf("overruns%0d", k), 64'(ovr_cnt[k]), 64'(ovr_exp[k]));
  endtask
  task automatic drain(input int k);
    while (rx_q[k].size() > 0) begin
      check($sformatf("m_valid%0d", k), 64'(m_valid_v[k]), 64'd1);
      check($sformatf("m_data%0d", k), 64'(m_data_a[k]), 64'(rx_q[k].pop_front()));
      m_ready_v[k] = 1'b1;
      @(negedge clk);
      m_ready_v[k] = 1'b0;
    end
    check($sformatf("m_empty%0d", k), 64'(m_valid_v[k]), 64'd0);
  endtask
  initial begin
    vec_t vt [5];
    logic [63:0] got;
    int k, np, nw;
    vt[0] = '{0, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    vt[1] = '{1, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    vt[2] = '{2, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    vt[3] = '{3, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    vt[4] = '{4, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
    cs_v = '1;
    sclk_v = 5'b01100;
    mosi_v = '0;
    s_valid_v = '0;
    m_ready_v = '0;
    for (int i = 0; i < N; i++) s_data_a[i] = '0;
    wait_cyc(3);
    check("rst_s_ready", 64'(s_ready_v), 64'h1F);
    check("rst_m_valid", 64'(m_valid_v), 64'h0);
    check("rst_miso", 64'(miso_v), 64'h0);
    check("rst_underrun", 64'(und_v), 64'h0);
    check("rst_overrun", 64'(ovr_v), 64'h0);
    for (int i = 0; i < N; i++) check($sformatf("rst_m_data%0d", i), 64'(m_data_a[i]), 64'h0);
    rst_n = 1'b1;
    wait_cyc(3);
    for (int v = 0; v < 5; v++) begin
      push(vt[v].k, vt[v].tx);
      frame(vt[v].k, dw_of(vt[v].k), to_wire(vt[v].k, vt[v].mo), got);
      check($sformatf("tbl_miso%0d", v), 64'(from_wire(vt[v].k, got, 0)), 64'(vt[v].exp_miso));
      check($sformatf("tbl_rx%0d", v), 64'(m_data_a[vt[v].k]), 64'(vt[v].exp_rx));
      drain(vt[v].k);
    end
    // underrun on the first word, FIFO refilled while it is still shifting
    fork
      frame(0, 16, to_wire(0, 16'hC3) | (to_wire(0, 16'h96) << 8), got);
      begin
        wait_cyc(30);
        push(0, 16'h5A);
      end
    join
    check("udr_word0", 64'(from_wire(0, got, 0)), 64'h00);
    check("udr_word1", 64'(from_wire(0, got, 1)), 64'h5A);
    drain(0);
    for (int i = 0; i < 5; i++) frame(1, 8, to_wire(1, 16'(8'h11 * (i + 1))), got);
    check("ovr_held", 64'(rx_q[1].size()), 64'd4);
    drain(1);
    frame(0, 5, to_wire(0, 16'hFF), got);
    drain(0);
    push(0, 16'h81);
    frame(0, 8, to_wire(0, 16'h42), got);
    check("abort_next_rx", 64'(m_data_a[0]), 64'h42);
    drain(0);
    push(2, 16'hFF);
    frame(3, 8, to_wire(3, 16'h99), got);
    cs_v[2] = 1'b0;
    wait_cyc(H);
    sclk_v[2] = 1'b0;
    wait_cyc(H);
    sclk_v[2] = 1'b1;
    wait_cyc(H);
    check("mid_miso_high", 64'(miso_v[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_miso", 64'(miso_v), 64'h0);
    check("mrst_s_ready", 64'(s_ready_v), 64'h1F);
    check("mrst_m_valid", 64'(m_valid_v), 64'h0);
    check("mrst_m_data3", 64'(m_data_a[3]), 64'h0);
    check("mrst_pulses", 64'({und_v, ovr_v}), 64'h0);
    cs_v[2] = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      tx_q[i].delete();
      rx_q[i].delete();
    end
    wait_cyc(4);
    check("post_rst_m_valid", 64'(m_valid_v), 64'h0);
    frame(2, 8, to_wire(2, 16'h0F), got);
    check("post_rst_tx_empty", 64'(from_wire(2, got, 0)), 64'h0);
    drain(2);
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 4);
      np = $urandom_range(0, 2);
      nw = $urandom_range(1, 2);
      for (int j = 0; j < np; j++) if (tx_q[k].size() < 4) push(k, 16'($urandom));
      frame(k, nw * dw_of(k), {$urandom, $urandom}, got);
      if ($urandom_range(0, 1) == 0) drain(k);
    end
    for (int i = 0; i < N; i++) drain(i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
